// File: rtl/sar_ctrl.sv
// -----------------------------------------------------------------------------
// sar_ctrl -- successive-approximation conversion controller.
//
// Sequences the samp_hold front end through non-overlapping sample and hold
// phases, then walks an NBITS binary search on the capacitive DAC using the
// comparator decision, and publishes the resolved code with a one-cycle
// dout_valid pulse.  Conversions repeat back to back while en is high.
//
// Sequence per conversion (cycles):
//   SAMP  (SAMP_CYC) -> NOVL1 (NOVL_CYC) -> CONV (NBITS) -> DONE (NOVL_CYC)
//
// Parameters:
//   NBITS     resolution, 2..16
//   SAMP_CYC  cycles with samp high, >= 1
//   NOVL_CYC  dead cycles on each side of hold, >= 1
//
// Ports:
//   clk         in   conversion clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   conversion enable; low forces IDLE on the next edge
//   cmp         in   comparator decision (1: held input >= DAC level)
//   samp        out  sample phase to samp_hold
//   hold        out  hold phase to samp_hold
//   cmp_strobe  out  comparator latch enable, high in every CONV cycle
//   dac_code    out  trial / resolved DAC code
//   dout        out  last completed conversion result
//   dout_valid  out  one-cycle pulse when dout updates
//   busy        out  high in every state except IDLE
//
// Optional feature macro: SAR_TWOS_COMP_EN
//   defined   : dout is two's complement (MSB of the final code inverted)
//   undefined : dout is offset binary, identical to the final dac_code
// -----------------------------------------------------------------------------
module sar_ctrl #(
    parameter int NBITS    = 8,
    parameter int SAMP_CYC = 4,
    parameter int NOVL_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cmp,
    output logic             samp,
    output logic             hold,
    output logic             cmp_strobe,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid,
    output logic             busy
);
    localparam int IW   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int CMAX = (SAMP_CYC > NOVL_CYC) ? SAMP_CYC : NOVL_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [IW-1:0]    IDX_MSB   = IW'(NBITS - 1);
    localparam logic [IW-1:0]    IDX_ONE   = IW'(1);
    localparam logic [IW-1:0]    IDX_ZERO  = IW'(0);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]    SAMP_LAST = CW'(SAMP_CYC - 1);
    localparam logic [CW-1:0]    NOVL_LAST = CW'(NOVL_CYC - 1);
    localparam logic [NBITS-1:0] MIDSCALE  = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-1:0] CODE_ZERO = {NBITS{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SAMP  = 3'd1,
        S_NOVL1 = 3'd2,
        S_CONV  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic [NBITS-1:0] dac_q;
    logic [NBITS-1:0] dout_q;
    logic             samp_q;
    logic             hold_q;
    logic             strobe_q;
    logic             valid_q;
    logic             busy_q;

    logic [NBITS-1:0] dac_res_d;   // current trial with bit idx resolved by cmp
    logic [NBITS-1:0] dac_next_d;  // resolved code plus the next trial bit

    // Output formatting of a finished code (offset binary or two's complement).
    function automatic logic [NBITS-1:0] fmt_dout(input logic [NBITS-1:0] code);
`ifdef SAR_TWOS_COMP_EN
        return {~code[NBITS-1], code[NBITS-2:0]};
`else
        return code;
`endif
    endfunction

    // Resolve the bit under test and prepare the next trial bit.
    always_comb begin
        dac_res_d         = dac_q;
        dac_res_d[idx_q]  = cmp;
        dac_next_d        = dac_res_d;
        if (idx_q != IDX_ZERO) begin
            dac_next_d[idx_q - IDX_ONE] = 1'b1;
        end else begin
            dac_next_d = dac_res_d;
        end
    end

    // Conversion FSM with registered phase, code and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            idx_q    <= IDX_ZERO;
            dac_q    <= CODE_ZERO;
            dout_q   <= CODE_ZERO;
            samp_q   <= 1'b0;
            hold_q   <= 1'b0;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (!en) begin
            // Abort: a partial conversion is dropped, dout is left untouched.
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            samp_q   <= 1'b0;
            hold_q   <= 1'b0;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_SAMP;
                    cnt_q   <= CNT_ZERO;
                    samp_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    valid_q <= 1'b0;
                end
                S_SAMP: begin
                    if (cnt_q == SAMP_LAST) begin
                        state_q <= S_NOVL1;
                        cnt_q   <= CNT_ZERO;
                        samp_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_NOVL1: begin
                    if (cnt_q == NOVL_LAST) begin
                        state_q  <= S_CONV;
                        cnt_q    <= CNT_ZERO;
                        idx_q    <= IDX_MSB;
                        dac_q    <= MIDSCALE;
                        hold_q   <= 1'b1;
                        strobe_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_CONV: begin
                    if (idx_q == IDX_ZERO) begin
                        state_q  <= S_DONE;
                        cnt_q    <= CNT_ZERO;
                        dac_q    <= dac_res_d;
                        dout_q   <= fmt_dout(dac_res_d);
                        valid_q  <= 1'b1;
                        hold_q   <= 1'b0;
                        strobe_q <= 1'b0;
                    end else begin
                        dac_q <= dac_next_d;
                        idx_q <= idx_q - IDX_ONE;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    if (cnt_q == NOVL_LAST) begin
                        // en is known high here, so chain into the next sample.
                        state_q <= S_SAMP;
                        cnt_q   <= CNT_ZERO;
                        samp_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    cnt_q    <= CNT_ZERO;
                    samp_q   <= 1'b0;
                    hold_q   <= 1'b0;
                    strobe_q <= 1'b0;
                    valid_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign samp       = samp_q;
    assign hold       = hold_q;
    assign cmp_strobe = strobe_q;
    assign dac_code   = dac_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sar_ctrl.  Two instances: the default build
// (NBITS=8, SAMP_CYC=4, NOVL_CYC=1) and a small build (NBITS=4, SAMP_CYC=2,
// NOVL_CYC=3).  The comparator is modelled in the loop as (target >= dac_code);
// expected phases, trial codes and results are computed from the conversion
// rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_sar_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en_a, cmp_a, en_b, cmp_b;
    logic       samp_a, hold_a, strb_a, valid_a, busy_a;
    logic [7:0] dac_a, dout_a;
    logic       samp_b, hold_b, strb_b, valid_b, busy_b;
    logic [3:0] dac_b, dout_b;

    sar_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .cmp(cmp_a),
        .samp(samp_a), .hold(hold_a), .cmp_strobe(strb_a),
        .dac_code(dac_a), .dout(dout_a), .dout_valid(valid_a), .busy(busy_a)
    );

    sar_ctrl #(.NBITS(4), .SAMP_CYC(2), .NOVL_CYC(3)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .cmp(cmp_b),
        .samp(samp_b), .hold(hold_b), .cmp_strobe(strb_b),
        .dac_code(dac_b), .dout(dout_b), .dout_valid(valid_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int tgt_a    = 0;
    int tgt_b    = 0;

    typedef struct {
        int target;
        int exp_code;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Comparator in the loop: decision against the DAC level of this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cmp_a = (tgt_a >= int'(dac_a));
        cmp_b = (tgt_b >= int'(dac_b));
    endtask

    function automatic int fmt(input int code, input int nb);
`ifdef SAR_TWOS_COMP_EN
        return code ^ (1 << (nb - 1));
`else
        return code;
`endif
    endfunction

    // k-th trial of a binary search converging on target: resolved upper bits
    // of target plus the bit under test.
    function automatic int trial(input int target, input int nb, input int k);
        int sh;
        sh = nb - k;
        return ((target >> sh) << sh) | (1 << (nb - 1 - k));
    endfunction

    // {samp, hold, cmp_strobe, busy, dout_valid} expected c cycles after samp rises.
    function automatic logic [4:0] exp_vec(input int sc, input int nc, input int nb, input int c);
        logic s, h, v;
        s = (c < sc);
        h = (c >= sc + nc) && (c < sc + nc + nb);
        v = (c == sc + nc + nb);
        return {s, h, h, 1'b1, v};
    endfunction

    function automatic logic [4:0] act_vec(input int which);
        if (which == 0) return {samp_a, hold_a, strb_a, busy_a, valid_a};
        else            return {samp_b, hold_b, strb_b, busy_b, valid_b};
    endfunction

    function automatic int act_dac(input int which);
        if (which == 0) return int'(dac_a);
        else            return int'(dac_b);
    endfunction

    function automatic int act_dout(input int which);
        if (which == 0) return int'(dout_a);
        else            return int'(dout_b);
    endfunction

    // One full conversion, entered in the first samp cycle, left in the next one.
    task automatic conv(input int which, input int target, input int exp_code, input string tag);
        int sc, nc, nb, p;
        if (which == 0) begin
            sc = 4; nc = 1; nb = 8;
            tgt_a = target;
            cmp_a = (tgt_a >= int'(dac_a));
        end else begin
            sc = 2; nc = 3; nb = 4;
            tgt_b = target;
            cmp_b = (tgt_b >= int'(dac_b));
        end
        p = sc + 2 * nc + nb;
        for (int c = 0; c < p; c++) begin
            check({tag, "_phases"}, 32'(act_vec(which)), 32'(exp_vec(sc, nc, nb, c)));
            if (c >= sc + nc && c < sc + nc + nb)
                check({tag, "_dac"}, act_dac(which), trial(target, nb, c - sc - nc));
            if (c == sc + nc + nb)
                check({tag, "_dout"}, act_dout(which), fmt(exp_code, nb));
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        vecs[0] = '{32'hFF, 32'hFF};
        vecs[1] = '{32'h00, 32'h00};
        vecs[2] = '{32'h80, 32'h80};
        vecs[3] = '{32'h01, 32'h01};
        vecs[4] = '{32'h7F, 32'h7F};
        vecs[5] = '{32'hA5, 32'hA5};

        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; cmp_a = 1'b0; cmp_b = 1'b0;
        tick();
        tick();
        check("reset_a", {27'd0, act_vec(0)}, 32'd0);
        check("reset_dac_a", act_dac(0), 0);
        check("reset_dout_a", act_dout(0), 0);
        check("reset_b", {27'd0, act_vec(1)}, 32'd0);

        // Release with en high: SAMP on the next edge, then table-driven runs.
        rst_n = 1'b1; en_a = 1'b1;
        tick();
        check("start_samp", 32'(samp_a), 32'd1);
        for (int i = 0; i < 6; i++) conv(0, vecs[i].target, vecs[i].exp_code, "tbl");

        // Abort during CONV bit 5 of a new conversion.
        tgt_a = 32'h3C;
        for (int c = 0; c < 7; c++) begin
            check("abort_pre", 32'(act_vec(0)), 32'(exp_vec(4, 1, 8, c)));
            tick();
        end
        en_a = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abort_idle", 32'(act_vec(0)), 32'd0);
            check("abort_dout", act_dout(0), fmt(32'hA5, 8));
        end

        // Re-enable, then assert reset in the middle of CONV.
        en_a = 1'b1;
        tick();
        check("reen_samp", 32'(act_vec(0)), 32'(exp_vec(4, 1, 8, 0)));
        for (int c = 0; c < 8; c++) tick();
        check("midconv_hold", 32'(hold_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_vec", 32'(act_vec(0)), 32'd0);
        check("async_rst_dout", act_dout(0), 0);
        check("async_rst_dac", act_dac(0), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_hold_vec", 32'(act_vec(0)), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_dout", act_dout(0), 0);
        conv(0, 32'hA5, 32'hA5, "post_rst");

        // Random targets, back to back.
        for (int i = 0; i < 6; i++) begin
            t = int'($urandom_range(0, 255));
            conv(0, t, t, "rand_a");
        end

        // Small build: NBITS=4, SAMP_CYC=2, NOVL_CYC=3.
        en_a = 1'b0; en_b = 1'b1;
        tick();
        check("a_idle", 32'(act_vec(0)), 32'd0);
        conv(1, 9, 9, "b_9");
        t = int'($urandom_range(0, 15));
        conv(1, t, t, "b_rand");
        conv(1, 15, 15, "b_f");
        conv(1, 0, 0, "b_0");
        en_b = 1'b0;
        tick();
        check("b_idle", 32'(act_vec(1)), 32'd0);
        check("b_dout_keep", act_dout(1), fmt(0, 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
